icache_refill_ctrl: RTL
=======================

Name: icache_refill_ctrl

Overview:
- Sequences L1 instruction-cache miss service for fetch stage 1.
- Captures the miss address from the L1 I-cache and issues a single line request to lower memory with a request/grant handshake.
- Assembles the returned beats into one cache line and drives the cache write port (wrEnable/wrAddr/instBlock) for exactly one cycle.
- Sits between the L1 I-cache miss outputs and the lower memory hierarchy.

Parameters:
- SIZE_PC, 32: PC/address width.
- CACHE_WIDTH, 256: cache line width in bits (8 instructions).
- MEM_WIDTH, 64: memory return beat width in bits; CACHE_WIDTH is an integer multiple of it.
- BEATS, CACHE_WIDTH/MEM_WIDTH (4): derived, beats per line.
- OFFSET_BITS, log2(CACHE_WIDTH/8) (5): derived, byte-offset bits zeroed in the line address.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- miss_i  in  1  L1 I-cache miss for the current PC.
- missAddr_i  in  SIZE_PC  address that missed.
- flush_i  in  1  fetch redirect (recover/exception); cancels an ungranted request.
- memReq_o  out  1  line request to memory.
- memAddr_o  out  SIZE_PC  line-aligned request address.
- memGnt_i  in  1  memory accepted request (sampled only while memReq_o=1).
- memValid_i  in  1  return beat valid.
- memData_i  in  MEM_WIDTH  return beat data.
- wrEnable_o  out  1  cache line write strobe.
- wrAddr_o  out  SIZE_PC  line address being written.
- instBlock_o  out  CACHE_WIDTH  assembled line.
- busy_o  out  1  refill in progress (state != IDLE).
- refillCount_o  out  16  completed refills, saturating.

Behaviour:
- Reset: state=IDLE; all outputs 0; line buffer, beat counter and lineAddr cleared. Reset mid-refill abandons the refill with no write. Outstanding memory beats after reset are the memory side's responsibility.
- States: IDLE, REQ, FILL, WRITE, COOL. All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- IDLE: when miss_i=1 and flush_i=0, latch lineAddr = missAddr_i with bits [OFFSET_BITS-1:0] = 0, then go to REQ. If miss_i=1 and flush_i=1 in the same cycle, stay in IDLE.
- REQ: memReq_o=1 and memAddr_o=lineAddr, held stable until granted.
  - memGnt_i=1: go to FILL with beatCnt=0. Grant takes priority over a same-cycle flush_i, so the request is committed.
  - flush_i=1 and memGnt_i=0: drop the request and return to IDLE (memReq_o=0 next cycle).
  - memValid_i in REQ is ignored. Memory never returns a beat in the grant cycle.
  - miss_i deasserting in REQ does not cancel; only flush_i cancels.
- FILL:
  - Each cycle with memValid_i=1 writes memData_i into buffer[beatCnt*MEM_WIDTH +: MEM_WIDTH] and increments beatCnt. Beat 0 holds the lowest address.
  - Gaps (memValid_i=0) are allowed without limit.
  - The beat with beatCnt==BEATS-1 moves the FSM to WRITE.
  - flush_i is ignored in FILL; the line is still written because it is valid data.
- WRITE: wrEnable_o=1 for exactly one cycle, with wrAddr_o=lineAddr and instBlock_o=buffer. refillCount_o increments (saturating at 16'hFFFF). Go to COOL.
- COOL: one cycle in which miss_i is ignored. This covers the cache's one-cycle hit update, so a stale miss cannot cause a duplicate refill. Go to IDLE.
- wrAddr_o and instBlock_o hold their last written values outside WRITE. Consumers qualify them with wrEnable_o.
- Minimum miss-to-write latency: miss in cycle 0, memReq_o=1 in cycle 1, grant in cycle 1, beats in cycles 2..5, wrEnable_o=1 in cycle 6, busy_o=0 in cycle 8.
- Only one refill is outstanding at a time. Misses arriving while busy_o=1 are not queued.
- Address arithmetic is modulo 2^SIZE_PC. Line alignment uses only masking, with no addition.

Test Plan:
- Basic refill: miss_i=1 with missAddr_i=0x0000_1234, immediate grant, beats 0x11..,0x22..,0x33..,0x44.. on consecutive cycles -> memAddr_o=0x0000_1220. wrEnable_o is a 1-cycle pulse, wrAddr_o=0x0000_1220, instBlock_o={beat3,beat2,beat1,beat0}, refillCount_o=1.
- Grant stall and beat gaps: grant delayed 5 cycles; memValid_i pattern 1,0,0,1,1,0,1 -> memReq_o held 5 cycles with a stable address. Exactly one wrEnable_o after the 4th valid beat, and beat order is preserved.
- Flush before grant: miss, then flush_i=1 in REQ with memGnt_i=0 -> IDLE next cycle, no wrEnable_o, refillCount_o unchanged. A new miss to 0x40 then issues memAddr_o=0x40.
- Flush same cycle as grant, and flush in FILL: both complete the fill and produce one write of the granted line.
- Stale miss: miss_i held 1 through WRITE and COOL -> no second memReq_o until the cycle after COOL. A refill then starts only if miss_i is still 1 in IDLE.
- Reset after 2 of 4 beats -> all outputs 0 next cycle, no write. A fresh refill afterwards assembles a correct line, with no residue from the earlier beats.

Source files
------------

// File: rtl/icache_refill_ctrl_if.sv
// Memory-side bus of the I-cache refill controller: a single line request
// with request/grant handshake, followed by a stream of return beats.
interface icache_refill_ctrl_if #(
  parameter int SIZE_PC   = 32,
  parameter int MEM_WIDTH = 64
) ();

  logic                 memReq_o;    // line request to memory
  logic [SIZE_PC-1:0]   memAddr_o;   // line-aligned request address
  logic                 memGnt_i;    // memory accepted the request
  logic                 memValid_i;  // return beat valid
  logic [MEM_WIDTH-1:0] memData_i;   // return beat data

  // Refill controller side: issues requests, consumes beats.
  modport master (
    output memReq_o,
    output memAddr_o,
    input  memGnt_i,
    input  memValid_i,
    input  memData_i
  );

  // Lower memory side: accepts requests, produces beats.
  modport slave (
    input  memReq_o,
    input  memAddr_o,
    output memGnt_i,
    output memValid_i,
    output memData_i
  );

endinterface

// File: rtl/icache_refill_ctrl.sv
// L1 instruction-cache refill controller. Captures a miss address, issues
// one line request to lower memory, assembles the returned beats into a
// cache line and writes it into the cache for exactly one cycle. A one-cycle
// cool-down after the write keeps a stale miss from starting a duplicate
// refill while the cache updates its tags.
module icache_refill_ctrl #(
  parameter int SIZE_PC     = 32,
  parameter int CACHE_WIDTH = 256,
  parameter int MEM_WIDTH   = 64
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   miss_i,
  input  logic [SIZE_PC-1:0]     missAddr_i,
  input  logic                   flush_i,

  icache_refill_ctrl_if.master   memBus,

  output logic                   wrEnable_o,
  output logic [SIZE_PC-1:0]     wrAddr_o,
  output logic [CACHE_WIDTH-1:0] instBlock_o,
  output logic                   busy_o,
  output logic [15:0]            refillCount_o
);

  localparam int BEATS       = CACHE_WIDTH / MEM_WIDTH;
  localparam int OFFSET_BITS = $clog2(CACHE_WIDTH / 8);
  localparam int BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FILL,
    WRITE,
    COOL
  } state_t;

  state_t                 state;
  state_t                 nextState;

  logic [SIZE_PC-1:0]     lineAddr;
  logic [BEAT_W-1:0]      beatCnt;
  logic [CACHE_WIDTH-1:0] lineBuf;
  logic [CACHE_WIDTH-1:0] mergedLine;
  logic [SIZE_PC-1:0]     wrAddrQ;
  logic [CACHE_WIDTH-1:0] instBlockQ;
  logic [15:0]            refillCnt;

  logic                   reqDec;
  logic                   wrDec;
  logic                   busyDec;

  logic                   missAccept;
  logic                   beatAccept;
  logic                   lastBeat;

  // Qualified events shared by the FSM and the datapath.
  assign missAccept = (state == IDLE) && miss_i && !flush_i;
  assign beatAccept = (state == FILL) && memBus.memValid_i;
  assign lastBeat   = beatAccept && (beatCnt == LAST_BEAT);

  // State register.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and state-decoded outputs; grant outranks a same-cycle flush.
  // NOTE: every output gets a default first so no branch can infer a latch.
  always_comb begin
    nextState = state;
    reqDec    = 1'b0;
    wrDec     = 1'b0;
    busyDec   = 1'b1;
    case (state)
      IDLE: begin
        busyDec = 1'b0;
        if (missAccept) begin
          nextState = REQ;
        end
      end
      REQ: begin
        reqDec = 1'b1;
        if (memBus.memGnt_i) begin
          nextState = FILL;
        end else if (flush_i) begin
          nextState = IDLE;
        end
      end
      FILL: begin
        if (lastBeat) begin
          nextState = WRITE;
        end
      end
      WRITE: begin
        wrDec     = 1'b1;
        nextState = COOL;
      end
      COOL: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Current line buffer with the incoming beat dropped into its slot.
  always_comb begin
    mergedLine = lineBuf;
    mergedLine[beatCnt*MEM_WIDTH +: MEM_WIDTH] = memBus.memData_i;
  end

  // Line address capture: offset bits are masked, never added to.
  always_ff @(posedge clk) begin
    if (reset) begin
      lineAddr <= '0;
    end else if (missAccept) begin
      lineAddr <= {missAddr_i[SIZE_PC-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    end
  end

  // Beat counter: restarts on grant, advances on every valid beat in FILL.
  always_ff @(posedge clk) begin
    if (reset) begin
      beatCnt <= '0;
    end else if ((state == REQ) && memBus.memGnt_i) begin
      beatCnt <= '0;
    end else if (beatAccept) begin
      beatCnt <= beatCnt + BEAT_W'(1);
    end
  end

  // Line assembly buffer; beat 0 lands in the least significant slice.
  // NOTE: the buffer is a plain flop bank, so clearing it on reset is cheap
  // and keeps an abandoned refill from leaving any trace.
  always_ff @(posedge clk) begin
    if (reset) begin
      lineBuf <= '0;
    end else if (beatAccept) begin
      lineBuf <= mergedLine;
    end
  end

  // Write-port registers: loaded with the complete line on the last beat,
  // so they are valid in WRITE and hold their value afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrAddrQ    <= '0;
      instBlockQ <= '0;
    end else if (lastBeat) begin
      wrAddrQ    <= lineAddr;
      instBlockQ <= mergedLine;
    end
  end

  // Completed-refill counter, saturating at all ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      refillCnt <= '0;
    end else if ((state == WRITE) && (refillCnt != 16'hFFFF)) begin
      refillCnt <= refillCnt + 16'd1;
    end
  end

  assign memBus.memReq_o  = reqDec;
  assign memBus.memAddr_o = lineAddr;

  assign wrEnable_o    = wrDec;
  assign wrAddr_o      = wrAddrQ;
  assign instBlock_o   = instBlockQ;
  assign busy_o        = busyDec;
  assign refillCount_o = refillCnt;

endmodule
